fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Write-side scheduler for the 4096x16 telemetry FIFO: shares the FIFO's single 16-bit write port between N_SRC sample sources (IMU, receiver, motor, status), one packet at a time, round-robin. It runs in the FIFO write clock domain and frames every packet with a header word so the byte-wide read side can demultiplex the stream. Backpressure comes only from the FIFO `full` flag. The block also bounds packet length and recovers from stalled sources.

## Interface
- N_SRC, 4, number of sources, 2..16
- MAX_LEN, 16, maximum payload words per packet, 1..255
- TIMEOUT, 1000, idle cycles tolerated mid-packet before abort, 2..65535
- clk  in  1  FIFO write clock (`wr_clk` domain)
- rst  in  1  synchronous, active-high reset
- src_valid  in  N_SRC  source i has a word on its data lane
- src_last  in  N_SRC  word on lane i is the last of its packet
- src_data  in  16*N_SRC  lane i = bits [16i+15:16i]
- src_ready  out  N_SRC  word on lane i accepted this cycle when it coincides with valid
- fifo_din  out  16  to FIFO `din`
- fifo_wr_en  out  1  to FIFO `wr_en`
- fifo_full  in  1  from FIFO `full`
- busy  out  1  state != IDLE
- grant  out  4  index of the source currently owning the FIFO (0 in IDLE)
- abort_count  out  8  number of timeout aborts, saturates at 255

## Operation
- States: IDLE, HEADER, PAYLOAD, ABORT.
- IDLE:
  - Search src_valid starting at rr_ptr, wrapping modulo N_SRC. The first asserted index becomes grant.
  - Next state HEADER; rr_ptr <= grant+1 mod N_SRC.
  - With no valid, stay in IDLE.
- HEADER:
  - fifo_din = {4'hA, grant[3:0], seq[grant][7:0]}; fifo_wr_en = !fifo_full.
  - On write: seq[grant] increments, wrapping 255->0; word_cnt <= 0; idle_cnt <= 0; go PAYLOAD.
  - While full, hold.
- PAYLOAD:
  - src_ready[grant] = !fifo_full. All other ready bits are 0.
  - fifo_din = granted lane; fifo_wr_en = src_valid[grant] & !fifo_full.
  - On each write: word_cnt++ and idle_cnt <= 0.
  - Go to IDLE on a write with src_last[grant], or on a write that makes word_cnt == MAX_LEN (truncation). After truncation, the source's remaining words form a new packet with a new header at its next grant.
  - idle_cnt increments only in cycles where src_valid[grant]=0. Cycles stalled by full do not count.
  - When idle_cnt reaches TIMEOUT-1 with valid low, go to ABORT.
- ABORT:
  - fifo_din = 16'hDEAD; fifo_wr_en = !fifo_full.
  - On write: abort_count increments, saturating; go IDLE. While full, hold.
- fifo_din and fifo_wr_en are combinational from state and inputs; there is no output register. This ensures a write is never issued in a cycle where full=1.
- src_ready is 0 in IDLE, HEADER and ABORT.
- Reset values: state IDLE, rr_ptr 0, all seq 0, word_cnt 0, idle_cnt 0, abort_count 0. Resulting outputs: src_ready 0, fifo_wr_en 0, fifo_din 0, busy 0, grant 0.
- Reset mid-packet: the packet is abandoned. No ABORT marker is written and the FIFO contents are untouched.

## Timing
- Request to header write: valid seen in IDLE at cycle t → header written at t+1 if not full.
- First payload word is accepted at t+2 at the earliest.
- Packet of L words with no backpressure occupies L+1 write cycles plus 1 IDLE arbitration cycle.
- Back-to-back packets leave one write-idle cycle between them (the IDLE cycle).
- fifo_full is sampled in the same cycle as the write decision, so writes stop with zero-cycle latency.
- Grant changes only in IDLE. A source that keeps valid high cannot block others: rr_ptr has already advanced past it.
- Simultaneous last and MAX_LEN on the same word: single end, with no truncation effect.

## Test plan
- Single source 1, three words 0x1111/0x2222/0x3333 with last on the third → FIFO receives 0xA100, 0x1111, 0x2222, 0x3333; busy low 1 cycle after the last write.
- Sources 0 and 2 both valid from reset, each sending 2 words, repeated → headers alternate 0xA000, 0xA200, 0xA001, 0xA201; no interleaving of payloads.
- fifo_full held high for 5 cycles mid-packet → fifo_wr_en=0 and src_ready=0 for exactly those cycles; no word lost or duplicated; idle_cnt not advanced.
- MAX_LEN=4, source 3 streams 6 words with last on the 6th → 0xA300 + 4 words, then 0xA301 + 2 words.
- TIMEOUT=8, source 1 sends 1 word then drops valid → 0xDEAD written 8 cycles later; abort_count=1; source 0 is granted next.
- rst pulsed during PAYLOAD → next cycle all outputs at reset values; the following packet from the same source carries seq 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side scheduler for the shared telemetry FIFO: frames each
// source packet with a header word, bounds packet length and aborts stalled packets.
module fifo_write_arbiter #(
  parameter int N_SRC   = 4,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic [N_SRC-1:0]     src_last,
  input  logic [16*N_SRC-1:0]  src_data,
  output logic [N_SRC-1:0]     src_ready,
  output logic [15:0]          fifo_din,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  output logic                 busy,
  output logic [3:0]           grant,
  output logic [7:0]           abort_count
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_ABORT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [7:0]      seq_q [N_SRC];
  logic            seq_inc_s;
  logic [7:0]      word_cnt_q, word_cnt_d;
  logic [15:0]     idle_cnt_q, idle_cnt_d;
  logic [7:0]      abort_cnt_q, abort_cnt_d;
  logic            found_s;
  logic [IW-1:0]   pick_s;
  logic [IW-1:0]   pick_next_s;
  logic            wr_s;
  logic [N_SRC-1:0] rdy_s;
  logic [15:0]     din_s;

  // Round-robin search; walking offsets downward lets the smallest offset win.
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= N_SRC) begin
        idx = idx - N_SRC;
      end else begin
        idx = idx;
      end
      if (src_valid[idx[IW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    pick_next_s = (pick_s == IW'(N_SRC - 1)) ? '0 : pick_s + 1'b1;
  end

  // Next-state and write-port control.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    word_cnt_d  = word_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    abort_cnt_d = abort_cnt_q;
    seq_inc_s   = 1'b0;
    rdy_s       = '0;
    din_s       = 16'h0000;
    wr_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          gnt_d   = pick_s;
          rr_d    = pick_next_s;
          state_d = S_HEADER;
        end else begin
          gnt_d   = '0;
        end
      end
      S_HEADER: begin
        din_s = {4'hA, grant, seq_q[gnt_q]};
        wr_s  = !fifo_full;
        if (!fifo_full) begin
          seq_inc_s  = 1'b1;
          word_cnt_d = 8'd0;
          idle_cnt_d = 16'd0;
          state_d    = S_PAYLOAD;
        end else begin
          state_d    = S_HEADER;
        end
      end
      S_PAYLOAD: begin
        rdy_s[gnt_q] = !fifo_full;
        din_s        = src_data[16*gnt_q +: 16];
        wr_s         = src_valid[gnt_q] & !fifo_full;
        if (wr_s) begin
          word_cnt_d = word_cnt_q + 8'd1;
          idle_cnt_d = 16'd0;
          // Last and length limit on the same word is a single ordinary end.
          if (src_last[gnt_q] || (word_cnt_q == 8'(MAX_LEN - 1))) begin
            state_d = S_IDLE;
            gnt_d   = '0;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else if (!src_valid[gnt_q]) begin
          idle_cnt_d = idle_cnt_q + 16'd1;
          if (idle_cnt_q == 16'(TIMEOUT - 2)) begin
            state_d = S_ABORT;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          // Source ready but FIFO full: the stall is not idle time.
          idle_cnt_d = idle_cnt_q;
        end
      end
      S_ABORT: begin
        din_s = 16'hDEAD;
        wr_s  = !fifo_full;
        if (!fifo_full) begin
          abort_cnt_d = (abort_cnt_q == 8'hFF) ? abort_cnt_q : abort_cnt_q + 8'd1;
          state_d     = S_IDLE;
          gnt_d       = '0;
        end else begin
          state_d     = S_ABORT;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      word_cnt_q  <= 8'd0;
      idle_cnt_q  <= 16'd0;
      abort_cnt_q <= 8'd0;
      for (int i = 0; i < N_SRC; i++) begin
        seq_q[i] <= 8'd0;
      end
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      word_cnt_q  <= word_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      if (seq_inc_s) begin
        seq_q[gnt_q] <= seq_q[gnt_q] + 8'd1;
      end
    end
  end

  // Reset abandons the packet at once: no write or handshake in the reset cycle.
  assign fifo_wr_en  = wr_s & ~rst;
  assign src_ready   = rst ? '0 : rdy_s;
  assign fifo_din    = rst ? 16'h0000 : din_s;
  assign busy        = (state_q != S_IDLE);
  assign grant       = 4'(gnt_q);
  assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: source queues feed the lanes and a
// scoreboard of expected FIFO words is checked on every write.
module tb_fifo_write_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_last;
  logic [16*N-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic [15:0]     fifo_din;
  logic            fifo_wr_en;
  logic            fifo_full;
  logic            busy;
  logic [3:0]      grant;
  logic [7:0]      abort_count;

  fifo_write_arbiter #(.N_SRC(N), .MAX_LEN(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_last(src_last), .src_data(src_data),
    .src_ready(src_ready),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .busy(busy), .grant(grant), .abort_count(abort_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] srcq [N][$];
  logic [15:0] sb [$];
  int          wr_log [$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          c0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        src_valid[i]         = 1'b1;
        src_last[i]          = srcq[i][0][16];
        src_data[16*i +: 16] = srcq[i][0][15:0];
      end else begin
        src_valid[i]         = 1'b0;
        src_last[i]          = 1'b0;
        src_data[16*i +: 16] = 16'h0000;
      end
    end
  endtask

  task automatic load(input int s, input logic l, input logic [15:0] d);
    srcq[s].push_back({l, d});
  endtask

  task automatic step();
    logic [N-1:0] acc;
    #1;
    if (fifo_full) check("no_wr_when_full", 32'(fifo_wr_en), 32'd0);
    if (fifo_wr_en) begin
      if (sb.size() == 0) begin
        check("extra_write", 32'(fifo_din), 32'h0001_0000);
      end else begin
        check("fifo_din", 32'(fifo_din), 32'(sb.pop_front()));
        wr_log.push_back(cyc);
      end
    end
    acc = src_valid & src_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (acc[i]) void'(srcq[i].pop_front());
    drive();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check({tag, "_din"},   32'(fifo_din), 32'd0);
    check({tag, "_ready"}, 32'(src_ready), 32'd0);
    check({tag, "_abort"}, 32'(abort_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    sb.delete();
    drive();
    step();
    step();
    rst = 1'b0;
    #1;
    check_idle_outputs(tag);
    wr_log.delete();
  endtask

  task automatic run_done(input int budget, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    fifo_full = 1'b0;
    src_valid = '0;
    src_last = '0;
    src_data = '0;
    @(negedge clk);

    // Single source, three words
    do_reset("rst1");
    load(1, 1'b0, 16'h1111); load(1, 1'b0, 16'h2222); load(1, 1'b1, 16'h3333);
    drive();
    sb.push_back(16'hA100); sb.push_back(16'h1111);
    sb.push_back(16'h2222); sb.push_back(16'h3333);
    c0 = cyc;
    for (int k = 0; k < 4; k++) step();
    check("t1_busy_on_last", 32'(busy), 32'd1);
    step();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_hdr_cycle", 32'(wr_log[0] - c0), 32'd1);
    check("t1_last_cycle", 32'(wr_log[3] - c0), 32'd4);

    // Two competing sources alternate
    do_reset("rst2");
    load(0, 1'b0, 16'h0A01); load(0, 1'b1, 16'h0A02);
    load(0, 1'b0, 16'h0A03); load(0, 1'b1, 16'h0A04);
    load(2, 1'b0, 16'h2A01); load(2, 1'b1, 16'h2A02);
    load(2, 1'b0, 16'h2A03); load(2, 1'b1, 16'h2A04);
    drive();
    sb.push_back(16'hA000); sb.push_back(16'h0A01); sb.push_back(16'h0A02);
    sb.push_back(16'hA200); sb.push_back(16'h2A01); sb.push_back(16'h2A02);
    sb.push_back(16'hA001); sb.push_back(16'h0A03); sb.push_back(16'h0A04);
    sb.push_back(16'hA201); sb.push_back(16'h2A03); sb.push_back(16'h2A04);
    run_done(40, "t2");
    check("t2_gap", 32'(wr_log[3] - wr_log[2]), 32'd2);

    // FIFO full for five cycles mid-packet
    do_reset("rst3");
    load(2, 1'b0, 16'h5001); load(2, 1'b0, 16'h5002); load(2, 1'b1, 16'h5003);
    drive();
    sb.push_back(16'hA200); sb.push_back(16'h5001);
    sb.push_back(16'h5002); sb.push_back(16'h5003);
    c0 = cyc;
    for (int k = 0; k < 3; k++) step();
    for (int k = 0; k < 5; k++) begin
      fifo_full = 1'b1;
      #1;
      check("t3_wr_en_full", 32'(fifo_wr_en), 32'd0);
      check("t3_ready_full", 32'(src_ready), 32'd0);
      step();
    end
    fifo_full = 1'b0;
    run_done(20, "t3");
    check("t3_resume_cycle", 32'(wr_log[2] - c0), 32'd8);

    // Truncation at MAX_LEN=4
    do_reset("rst4");
    for (int k = 1; k <= 6; k++) load(3, (k == 6), 16'h3000 + 16'(k));
    drive();
    sb.push_back(16'hA300);
    for (int k = 1; k <= 4; k++) sb.push_back(16'h3000 + 16'(k));
    sb.push_back(16'hA301);
    sb.push_back(16'h3005); sb.push_back(16'h3006);
    step();
    #1;
    check("t4_grant", 32'(grant), 32'd3);
    run_done(30, "t4");

    // Timeout abort with TIMEOUT=8, then source 0 served
    do_reset("rst5");
    load(1, 1'b0, 16'h1BEE);
    drive();
    sb.push_back(16'hA100); sb.push_back(16'h1BEE);
    c0 = cyc;
    step();
    load(0, 1'b1, 16'h0C0D);
    drive();
    sb.push_back(16'hDEAD); sb.push_back(16'hA000); sb.push_back(16'h0C0D);
    run_done(40, "t5");
    check("t5_dead_delay", 32'(wr_log[2] - wr_log[1]), 32'd8);
    check("t5_dead_cycle", 32'(wr_log[2] - c0), 32'd10);
    check("t5_abort_count", 32'(abort_count), 32'd1);

    // Reset in the middle of a payload
    do_reset("rst6");
    load(1, 1'b0, 16'h6001); load(1, 1'b0, 16'h6002); load(1, 1'b1, 16'h6003);
    drive();
    sb.push_back(16'hA100); sb.push_back(16'h6001);
    step(); step(); step();
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_wr_en_in_rst", 32'(fifo_wr_en), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_idle_outputs("t6_post");
    sb.push_back(16'hA100); sb.push_back(16'h6002); sb.push_back(16'h6003);
    run_done(20, "t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
